// File: rtl/demux_1_to_4_buffered_pkg.sv
// Shared constants and types for the buffered 1-to-4 demultiplexer.
package demux_pkg;

  localparam int NUM_CH    = 4;
  localparam int DEPTH_DEF = 2;

  typedef logic [1:0] chan_sel_t;

  // One-hot decode of a channel select.
  function automatic logic [NUM_CH-1:0] sel_onehot(input chan_sel_t sel);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_1_to_4_buffered_sync_fifo.sv
// Single-clock FIFO with registered storage; head word is read straight
// out of the storage array, so a push is visible only after its edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Full blocks pushes even when a pop happens at the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state for pointers (wrap via power-of-two width) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count registers; reset discards all buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; cleared on reset so outputs read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/demux_1_to_4_buffered.sv
// Routes one input stream to four independently buffered output channels.
// Only select decode and the ready mux live here; buffering is per-channel.
module demux_1_to_4_buffered
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [1:0]        in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data0,
  output logic [WIDTH-1:0]  out_data1,
  output logic [WIDTH-1:0]  out_data2,
  output logic [WIDTH-1:0]  out_data3,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready
);

  logic [NUM_CH-1:0]            full, empty, push, pop;
  logic [NUM_CH-1:0][WIDTH-1:0] head;
  chan_sel_t                    sel;

  assign sel       = chan_sel_t'(in_sel);
  // Ready depends only on the selected channel's fullness, never on valid.
  assign in_ready  = !full[sel];
  assign out_valid = ~empty;
  assign pop       = out_ready & ~empty;

  // Push strobe goes to the selected channel only.
  always_comb begin
    push = '0;
    if (in_valid && in_ready) push = sel_onehot(sel);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[i]),
      .data_i  (in_data),
      .full_o  (full[i]),
      .pop_i   (pop[i]),
      .empty_o (empty[i]),
      .data_o  (head[i])
    );
  end

  assign out_data0 = head[0];
  assign out_data1 = head[1];
  assign out_data2 = head[2];
  assign out_data3 = head[3];

endmodule

// File: tb/tb_demux_1_to_4_buffered.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// queue-per-channel reference model.
module tb_demux_1_to_4_buffered;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] q [4][$];

  demux_1_to_4_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] out_of(input int ch);
    case (ch)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      default: return out_data3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'b0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) q[c].delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 4'b0000) begin
      n_err++; $display("FAIL reset_valid got=%b exp=0000", out_valid);
    end
    for (int c = 0; c < 4; c++) begin
      in_sel = 2'(c);
      #1;
      n_cmp++;
      if (out_of(c) !== '0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_ch%0d data=%h ready=%b exp data=0 ready=1", c, out_of(c), in_ready);
      end
    end
    in_sel = 2'd0;
    rst_n = 1'b1;
  endtask

  // First push on the first edge after reset release.
  task automatic test_basic();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hAAAA0001;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (out_valid !== 4'b0100 || out_data2 !== 32'hAAAA0001) begin
      n_err++;
      $display("FAIL basic_push valid=%b data2=%h exp 0100/aaaa0001", out_valid, out_data2);
    end
    n_cmp++;
    if (out_data0 !== '0 || out_data1 !== '0 || out_data3 !== '0) begin
      n_err++;
      $display("FAIL basic_others d0=%h d1=%h d3=%h exp 0", out_data0, out_data1, out_data3);
    end
  endtask

  task automatic test_full();
    do_reset();
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL full_ready_sel1 got=%b exp=0", in_ready);
    end
    in_sel = 2'd0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL full_ready_sel0 got=%b exp=1", in_ready);
    end
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h33;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 4'b0010 || out_data1 !== 32'h11) begin
      n_err++;
      $display("FAIL full_no_third valid=%b data1=%h exp 0010/11", out_valid, out_data1);
    end
  endtask

  // Continues from a full channel 1 holding 0x11, 0x22.
  task automatic test_full_pop();
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h33; out_ready = 4'b0010;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL full_pop_passthru ready=%b exp=0", in_ready);
    end
    tick();
    idle_inputs();
    in_sel = 2'd1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_data1 !== 32'h22 || out_valid !== 4'b0010) begin
      n_err++;
      $display("FAIL full_pop_next ready=%b data1=%h valid=%b exp 1/22/0010", in_ready, out_data1, out_valid);
    end
    out_ready = 4'b0010;
    tick();
    out_ready = 4'b0000;
    #1;
    n_cmp++;
    if (out_valid !== 4'b0000) begin
      n_err++; $display("FAIL full_pop_drain valid=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_all_pop();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_sel = 2'(c); in_data = 32'h100 + 32'(c);
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 4'b1111) begin
      n_err++; $display("FAIL all_fill valid=%b exp=1111", out_valid);
    end
    in_valid = 1'b1; in_sel = 2'd3; in_data = 32'hBEEF; out_ready = 4'b1111;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (out_valid !== 4'b1000 || out_data3 !== 32'hBEEF) begin
      n_err++;
      $display("FAIL all_pop valid=%b data3=%h exp 1000/0000beef", out_valid, out_data3);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h5;
    tick();
    in_data = 32'h6;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (out_valid !== 4'b0001 || out_data0 !== 32'h5) begin
      n_err++; $display("FAIL arst_pre valid=%b data0=%h exp 0001/5", out_valid, out_data0);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 4'b0000 || out_data0 !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL arst_now valid=%b data0=%h ready=%b exp 0000/0/1", out_valid, out_data0, in_ready);
    end
    #1 rst_n = 1'b1;
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
    n_cmp++;
    if (out_valid !== 4'b0000) begin
      n_err++; $display("FAIL arst_after valid=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_random();
    logic [3:0]       exp_valid;
    logic             exp_ready;
    logic             push_ok;
    logic [1:0]       sel;
    logic [WIDTH-1:0] dat;
    logic             vld;
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      vld = ($urandom_range(0, 9) < 6);
      sel = 2'($urandom_range(0, 3));
      dat = $urandom;
      in_valid = vld; in_sel = sel; in_data = dat;
      out_ready = 4'($urandom);
      #1;
      for (int c = 0; c < 4; c++) exp_valid[c] = (q[c].size() > 0);
      exp_ready = (q[sel].size() < DEPTH);
      n_cmp++;
      if (out_valid !== exp_valid || in_ready !== exp_ready) begin
        n_err++;
        $display("FAIL rnd_flags cyc=%0d valid=%b ready=%b exp %b/%b", cyc, out_valid, in_ready, exp_valid, exp_ready);
      end
      for (int c = 0; c < 4; c++) begin
        if (q[c].size() > 0) begin
          n_cmp++;
          if (out_of(c) !== q[c][0]) begin
            n_err++;
            $display("FAIL rnd_head cyc=%0d ch=%0d got=%h exp=%h", cyc, c, out_of(c), q[c][0]);
          end
        end
      end
      push_ok = vld && exp_ready;
      for (int c = 0; c < 4; c++)
        if (out_ready[c] && q[c].size() > 0) void'(q[c].pop_front());
      if (push_ok) q[sel].push_back(dat);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_full();
    test_full_pop();
    test_all_pop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1_to_4_buffered.md
DEMUX_1_TO_4_BUFFERED -- requirements
Module: demux_1_to_4_buffered

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 2, per-channel buffer entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  WIDTH  word to route.
REQ-006 in_sel  input  2  destination channel, 0..3.
REQ-007 in_valid  input  1  in_data/in_sel valid.
REQ-008 in_ready  output  1  the channel selected by in_sel can accept a word.
REQ-009 out_data0..out_data3  output  WIDTH each  head word of channel 0..3.
REQ-010 out_valid  output  4  bit i set: channel i holds at least one word.
REQ-011 out_ready  input  4  bit i set: consumer i takes the head word.

Function
REQ-012 in_ready SHALL equal NOT full[in_sel], combinational, independent of in_valid.
REQ-013 Push SHALL occur on a rising edge with in_valid=1 and in_ready=1; the word is written to the tail of channel in_sel only.
REQ-014 Upstream SHALL hold in_data and in_sel stable while in_valid=1 and in_ready=0; the block does not check this.
REQ-015 out_valid[i] SHALL equal NOT empty[i]; out_dataI SHALL show the channel-i head entry, read directly from storage.
REQ-016 Pop SHALL occur on channel i on a rising edge with out_valid[i]=1 and out_ready[i]=1; out_ready[i] with out_valid[i]=0 has no effect.
REQ-017 Latency: a word pushed at edge N SHALL be visible at its output after edge N, at the earliest one cycle after presentation; there is no combinational input-to-output path.
REQ-018 Per-channel order SHALL be FIFO; there is no ordering between channels.
REQ-019 Each channel SHALL keep read pointer, write pointer and count (0..DEPTH); pointers wrap modulo DEPTH.
REQ-020 Push and pop on the same non-full, non-empty channel at one edge SHALL both take effect, with count unchanged.
REQ-021 A full channel SHALL have no pass-through: in_ready stays 0 even when the same channel pops in that cycle.
REQ-022 A push to an empty channel SHALL NOT be visible at the output in the same cycle.
REQ-023 Pops on all four channels and a push to any channel SHALL be able to complete at the same edge.
REQ-024 A full channel SHALL NOT stall pushes addressed to the other channels.

Reset
REQ-025 While rst_n=0, all pointers and counts SHALL be 0 and all storage cleared: out_valid=4'b0000, out_data0..3=0, and in_ready=1.
REQ-026 Reset asserted mid-operation SHALL discard all buffered words immediately; no pop is reported afterwards.
REQ-027 The first push SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-028 Package demux_pkg SHALL hold the NUM_CH=4 constant, the chan_sel_t typedef (2-bit), and the DEPTH default.
REQ-029 Sub-module sync_fifo (WIDTH, DEPTH; push/full, pop/empty, head data) SHALL be instanced once per channel; the top contains only select decode and ready mux.

Verification
REQ-030 Reset, then push 0xAAAA0001 to sel=2 with out_ready=0 -> next cycle out_valid=4'b0100, out_data2=0xAAAA0001, and the other outputs remain 0.
REQ-031 DEPTH=2: push 0x11 then 0x22 to sel=1 with out_ready=0 -> in_ready=0 while in_sel=1 and 1 while in_sel=0; a third sel=1 push is not accepted.
REQ-032 Channel 1 full, then out_ready[1]=1 with in_valid=1 and sel=1 for one cycle -> 0x11 popped, no push that cycle, in_ready=1 next cycle, then 0x22 appears at the head.
REQ-033 One word in each channel, then push to channel 3 while out_ready=4'b1111 -> all four pop, and out_valid=4'b1000 holding the new word.
REQ-034 Push 0x5 and 0x6 to channel 0, then assert rst_n=0 asynchronously mid-cycle -> out_valid=0 and out_data0=0 immediately, before the next edge.
REQ-035 Random sel/valid/ready over 10k cycles with a per-channel scoreboard -> no loss, duplication or reordering.
